// File: rtl/dispatch_ctrl_pkg.sv
// Shared definitions for the dispatch stage: reservation-station bit positions
// inside the one-hot rs_dest/rs_we/rs_full vectors, and the stage FSM encoding.
package dispatch_ctrl_pkg;

    // Bit index of each reservation station in the one-hot vectors (MSB..LSB).
    localparam int unsigned RS_ALU = 3;
    localparam int unsigned RS_BR  = 2;
    localparam int unsigned RS_LSU = 1;
    localparam int unsigned RS_FPU = 0;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        HALT  = 2'd2
    } dispatch_state_t;

endpackage

// File: rtl/dispatch_ctrl_sat_counter.sv
// Saturating up-counter: increments by one when inc is high, holds at all-ones.
// Ports: clk, rst_n (async active-low), inc (increment request), count (value).
module sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    // Hold at all-ones instead of wrapping back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/dispatch_ctrl.sv
// Single-issue dispatch stage controller. Holds one instruction from the
// instruction queue, presents it to decode, and fires it into the ROB and the
// one-hot target reservation station once both have room. Illegal opcodes are
// dispatched as ROB exceptions and halt the stage until a flush.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   iq_valid/iq_pc/iq_inst/iq_ready  instruction queue handshake
//   dc_pc/dc_inst                  registered instruction driven to decode
//   dc_rs_dest                     one-hot target RS from decode (0 = illegal)
//   rob_ready/rob_we/rob_exc       ROB allocation
//   rs_we/rs_full                  reservation station write / full flags
//   flush                          synchronous pipeline flush
//   halted                         stage is in HALT
//   cnt_disp/cnt_stall_rob/cnt_stall_rs  saturating performance counters
module dispatch_ctrl
    import dispatch_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32,
    parameter int unsigned N_RS  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iq_valid,
    input  logic [31:0]      iq_pc,
    input  logic [31:0]      iq_inst,
    output logic             iq_ready,
    output logic [31:0]      dc_pc,
    output logic [31:0]      dc_inst,
    input  logic [N_RS-1:0]  dc_rs_dest,
    input  logic             rob_ready,
    output logic             rob_we,
    output logic             rob_exc,
    output logic [N_RS-1:0]  rs_we,
    input  logic [N_RS-1:0]  rs_full,
    input  logic             flush,
    output logic             halted,
    output logic [CNT_W-1:0] cnt_disp,
    output logic [CNT_W-1:0] cnt_stall_rob,
    output logic [CNT_W-1:0] cnt_stall_rs
);

    dispatch_state_t state;
    dispatch_state_t state_nxt;

    logic illegal;
    logic rs_ok;
    logic fire;
    logic take;
    logic inc_disp;
    logic inc_stall_rob;
    logic inc_stall_rs;

    // Only the targeted station's full flag matters; illegal ops need no RS.
    assign illegal = (dc_rs_dest == '0);
    assign rs_ok   = illegal | (|(dc_rs_dest & ~rs_full));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake outputs; everything is forced low during reset.
    always_comb begin
        state_nxt     = state;
        fire          = 1'b0;
        take          = 1'b0;
        iq_ready      = 1'b0;
        rob_we        = 1'b0;
        rob_exc       = 1'b0;
        rs_we         = '0;
        halted        = 1'b0;
        inc_disp      = 1'b0;
        inc_stall_rob = 1'b0;
        inc_stall_rs  = 1'b0;

        if (rst_n) begin
            fire     = (state == FULL) & rob_ready & rs_ok & ~flush;
            iq_ready = ~flush & ((state == EMPTY) | ((state == FULL) & fire & ~illegal));
            take     = iq_valid & iq_ready;
            rob_we   = fire;
            rob_exc  = fire & illegal;
            rs_we    = (fire & ~illegal) ? dc_rs_dest : '0;
            halted   = (state == HALT);

            inc_disp      = fire;
            // ROB-full wins, so the two stall counters never step together.
            inc_stall_rob = (state == FULL) & ~rob_ready & ~flush;
            inc_stall_rs  = (state == FULL) & rob_ready & ~rs_ok & ~flush;

            unique case (state)
                EMPTY: begin
                    if (take) begin
                        state_nxt = FULL;
                    end
                end
                FULL: begin
                    if (fire) begin
                        if (illegal) begin
                            state_nxt = HALT;
                        end else if (take) begin
                            state_nxt = FULL;
                        end else begin
                            state_nxt = EMPTY;
                        end
                    end
                end
                HALT: begin
                    state_nxt = HALT;
                end
                default: begin
                    state_nxt = EMPTY;
                end
            endcase

            if (flush) begin
                state_nxt = EMPTY;
            end
        end
    end

    // Stage register; contents are stale (don't-care) once the stage is EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dc_pc   <= '0;
            dc_inst <= '0;
        end else if (take) begin
            dc_pc   <= iq_pc;
            dc_inst <= iq_inst;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_cnt_disp (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_disp),
        .count (cnt_disp)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall_rob (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stall_rob),
        .count (cnt_stall_rob)
    );

    sat_counter #(.CNT_W(CNT_W)) u_cnt_stall_rs (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (inc_stall_rs),
        .count (cnt_stall_rs)
    );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Directed bench for dispatch_ctrl. The bench plays the decode block, mapping
// the registered dc_inst opcode to a one-hot reservation station. A second
// instance with 4-bit counters exercises counter saturation.
module tb_dispatch_ctrl;
    import dispatch_ctrl_pkg::*;

    localparam logic [3:0] D_ALU = 4'b1000;
    localparam logic [3:0] D_LSU = 4'b0010;

    logic        clk;
    logic        rst_n;
    logic        iq_valid;
    logic [31:0] iq_pc;
    logic [31:0] iq_inst;
    logic        rob_ready;
    logic [3:0]  rs_full;
    logic        flush;

    logic        iq_ready;
    logic [31:0] dc_pc;
    logic [31:0] dc_inst;
    logic [3:0]  dc_rs_dest;
    logic        rob_we;
    logic        rob_exc;
    logic [3:0]  rs_we;
    logic        halted;
    logic [31:0] cnt_disp;
    logic [31:0] cnt_stall_rob;
    logic [31:0] cnt_stall_rs;

    logic        s_iq_ready;
    logic [31:0] s_dc_pc;
    logic [31:0] s_dc_inst;
    logic [3:0]  s_dc_rs_dest;
    logic        s_rob_we;
    logic        s_rob_exc;
    logic [3:0]  s_rs_we;
    logic        s_halted;
    logic [3:0]  s_cnt_disp;
    logic [3:0]  s_cnt_stall_rob;
    logic [3:0]  s_cnt_stall_rs;

    int n_chk;
    int n_fail;
    int exp_disp;

    function automatic logic [3:0] decode_rs(input logic [31:0] inst);
        logic [3:0] d;
        case (inst[6:0])
            7'h13, 7'h33, 7'h37, 7'h17: d = 4'(1 << RS_ALU);
            7'h63, 7'h6F, 7'h67:        d = 4'(1 << RS_BR);
            7'h03, 7'h23:               d = 4'(1 << RS_LSU);
            7'h07, 7'h27, 7'h53:        d = 4'(1 << RS_FPU);
            default:                    d = 4'b0000;
        endcase
        return d;
    endfunction

    assign dc_rs_dest   = decode_rs(dc_inst);
    assign s_dc_rs_dest = decode_rs(s_dc_inst);

    dispatch_ctrl #(.CNT_W(32), .N_RS(4)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .iq_valid      (iq_valid),
        .iq_pc         (iq_pc),
        .iq_inst       (iq_inst),
        .iq_ready      (iq_ready),
        .dc_pc         (dc_pc),
        .dc_inst       (dc_inst),
        .dc_rs_dest    (dc_rs_dest),
        .rob_ready     (rob_ready),
        .rob_we        (rob_we),
        .rob_exc       (rob_exc),
        .rs_we         (rs_we),
        .rs_full       (rs_full),
        .flush         (flush),
        .halted        (halted),
        .cnt_disp      (cnt_disp),
        .cnt_stall_rob (cnt_stall_rob),
        .cnt_stall_rs  (cnt_stall_rs)
    );

    dispatch_ctrl #(.CNT_W(4), .N_RS(4)) dut_small (
        .clk           (clk),
        .rst_n         (rst_n),
        .iq_valid      (iq_valid),
        .iq_pc         (iq_pc),
        .iq_inst       (iq_inst),
        .iq_ready      (s_iq_ready),
        .dc_pc         (s_dc_pc),
        .dc_inst       (s_dc_inst),
        .dc_rs_dest    (s_dc_rs_dest),
        .rob_ready     (rob_ready),
        .rob_we        (s_rob_we),
        .rob_exc       (s_rob_exc),
        .rs_we         (s_rs_we),
        .rs_full       (rs_full),
        .flush         (flush),
        .halted        (s_halted),
        .cnt_disp      (s_cnt_disp),
        .cnt_stall_rob (s_cnt_stall_rob),
        .cnt_stall_rs  (s_cnt_stall_rs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; iq_valid = 1'b1; iq_pc = 32'h0; iq_inst = 32'h00000013;
        rob_ready = 1'b1; rs_full = 4'b0000; flush = 1'b0;
        #1;
        n_chk++; if (iq_ready !== 1'b0) begin n_fail++; $display("FAIL reset_iq_ready: got %b want 0", iq_ready); end
        n_chk++; if (rob_we !== 1'b0 || rob_exc !== 1'b0 || rs_we !== 4'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL reset_strobes: got rob_we=%b rob_exc=%b rs_we=%b halted=%b want 0", rob_we, rob_exc, rs_we, halted); end
        tick(); tick();
        n_chk++; if (dc_pc !== 32'h0 || dc_inst !== 32'h0) begin n_fail++; $display("FAIL reset_stage: got pc=%h inst=%h want 0", dc_pc, dc_inst); end
        n_chk++; if (cnt_disp !== 32'd0 || cnt_stall_rob !== 32'd0 || cnt_stall_rs !== 32'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d/%0d/%0d want 0", cnt_disp, cnt_stall_rob, cnt_stall_rs); end
        iq_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        n_chk++; if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_iq_ready: got %b want 1", iq_ready); end
        tick();
    endtask

    task automatic test_single();
        iq_valid = 1'b1; iq_pc = 32'h0000_0100; iq_inst = 32'h00500093;
        tick();
        iq_valid = 1'b0;
        #1;
        n_chk++; if (dc_inst !== 32'h00500093 || dc_pc !== 32'h0000_0100) begin n_fail++; $display("FAIL single_stage: got pc=%h inst=%h want 00000100/00500093", dc_pc, dc_inst); end
        n_chk++; if (rob_we !== 1'b1 || rob_exc !== 1'b0) begin n_fail++; $display("FAIL single_rob: got we=%b exc=%b want 1/0", rob_we, rob_exc); end
        n_chk++; if (rs_we !== D_ALU) begin n_fail++; $display("FAIL single_rs_we: got %b want %b", rs_we, D_ALU); end
        tick();
        exp_disp = 1;
        n_chk++; if (cnt_disp !== 32'(exp_disp)) begin n_fail++; $display("FAIL single_cnt_disp: got %0d want %0d", cnt_disp, exp_disp); end
        n_chk++; if (rob_we !== 1'b0 || iq_ready !== 1'b1) begin n_fail++; $display("FAIL single_empty: got rob_we=%b iq_ready=%b want 0/1", rob_we, iq_ready); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] insts [4];
        logic [3:0]  dests [4];
        insts[0] = 32'h00100113; dests[0] = D_ALU;
        insts[1] = 32'h0000A103; dests[1] = D_LSU;
        insts[2] = 32'h002081B3; dests[2] = D_ALU;
        insts[3] = 32'h0040A223; dests[3] = D_LSU;
        iq_valid = 1'b1; iq_inst = insts[0]; iq_pc = 32'h200;
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                iq_valid = 1'b1; iq_inst = insts[i+1]; iq_pc = 32'h200 + 32'(4 * (i + 1));
            end else begin
                iq_valid = 1'b0;
            end
            #1;
            n_chk++; if (rob_we !== 1'b1 || rs_we !== dests[i] || dc_inst !== insts[i]) begin n_fail++; $display("FAIL b2b_fire%0d: got rob_we=%b rs_we=%b inst=%h want 1/%b/%h", i, rob_we, rs_we, dc_inst, dests[i], insts[i]); end
            n_chk++; if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_iq_ready%0d: got %b want 1", i, iq_ready); end
            tick();
        end
        exp_disp += 4;
        n_chk++; if (cnt_disp !== 32'(exp_disp)) begin n_fail++; $display("FAIL b2b_cnt_disp: got %0d want %0d", cnt_disp, exp_disp); end
    endtask

    task automatic test_stall_rs();
        iq_valid = 1'b1; iq_inst = 32'h0000A083; iq_pc = 32'h300;
        tick();
        iq_inst = 32'h00000013; rs_full = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_chk++; if (rs_we !== 4'b0 || rob_we !== 1'b0 || iq_ready !== 1'b0) begin n_fail++; $display("FAIL rs_stall%0d: got rs_we=%b rob_we=%b iq_ready=%b want 0/0/0", i, rs_we, rob_we, iq_ready); end
            tick();
        end
        // Non-targeted full flags must not block the load.
        rs_full = 4'b1101; iq_valid = 1'b0;
        #1;
        n_chk++; if (rs_we !== D_LSU || rob_we !== 1'b1 || iq_ready !== 1'b1) begin n_fail++; $display("FAIL rs_release: got rs_we=%b rob_we=%b iq_ready=%b want 0010/1/1", rs_we, rob_we, iq_ready); end
        tick();
        rs_full = 4'b0000;
        exp_disp += 1;
        n_chk++; if (cnt_stall_rs !== 32'd3 || cnt_stall_rob !== 32'd0) begin n_fail++; $display("FAIL rs_stall_cnt: got rs=%0d rob=%0d want 3/0", cnt_stall_rs, cnt_stall_rob); end
        n_chk++; if (cnt_disp !== 32'(exp_disp)) begin n_fail++; $display("FAIL rs_cnt_disp: got %0d want %0d", cnt_disp, exp_disp); end
    endtask

    task automatic test_stall_rob();
        iq_valid = 1'b1; iq_inst = 32'h0000A083; iq_pc = 32'h400;
        tick();
        iq_valid = 1'b0; rob_ready = 1'b0; rs_full = 4'b0010;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_chk++; if (rob_we !== 1'b0 || rs_we !== 4'b0) begin n_fail++; $display("FAIL rob_stall%0d: got rob_we=%b rs_we=%b want 0/0", i, rob_we, rs_we); end
            tick();
        end
        rob_ready = 1'b1; rs_full = 4'b0000;
        #1;
        n_chk++; if (rob_we !== 1'b1 || rs_we !== D_LSU) begin n_fail++; $display("FAIL rob_release: got rob_we=%b rs_we=%b want 1/0010", rob_we, rs_we); end
        tick();
        exp_disp += 1;
        n_chk++; if (cnt_stall_rob !== 32'd2 || cnt_stall_rs !== 32'd3) begin n_fail++; $display("FAIL rob_stall_cnt: got rob=%0d rs=%0d want 2/3", cnt_stall_rob, cnt_stall_rs); end
    endtask

    task automatic test_illegal();
        iq_valid = 1'b1; iq_inst = 32'h0000007F; iq_pc = 32'h500;
        tick();
        iq_inst = 32'h00000013;
        #1;
        n_chk++; if (rob_we !== 1'b1 || rob_exc !== 1'b1 || rs_we !== 4'b0) begin n_fail++; $display("FAIL illegal_fire: got rob_we=%b rob_exc=%b rs_we=%b want 1/1/0000", rob_we, rob_exc, rs_we); end
        n_chk++; if (iq_ready !== 1'b0) begin n_fail++; $display("FAIL illegal_iq_ready: got %b want 0", iq_ready); end
        tick();
        exp_disp += 1;
        n_chk++; if (halted !== 1'b1 || iq_ready !== 1'b0 || rob_we !== 1'b0) begin n_fail++; $display("FAIL halt_state: got halted=%b iq_ready=%b rob_we=%b want 1/0/0", halted, iq_ready, rob_we); end
        tick();
        n_chk++; if (halted !== 1'b1 || dc_inst !== 32'h0000007F || cnt_disp !== 32'(exp_disp)) begin n_fail++; $display("FAIL halt_hold: got halted=%b inst=%h disp=%0d want 1/0000007f/%0d", halted, dc_inst, cnt_disp, exp_disp); end
        flush = 1'b1;
        #1;
        n_chk++; if (iq_ready !== 1'b0 || rob_we !== 1'b0) begin n_fail++; $display("FAIL halt_flush_cycle: got iq_ready=%b rob_we=%b want 0/0", iq_ready, rob_we); end
        tick();
        flush = 1'b0;
        #1;
        n_chk++; if (halted !== 1'b0 || iq_ready !== 1'b1) begin n_fail++; $display("FAIL halt_exit: got halted=%b iq_ready=%b want 0/1", halted, iq_ready); end
        iq_valid = 1'b0;
        tick();
    endtask

    task automatic test_flush_fire();
        iq_valid = 1'b1; iq_inst = 32'h00000013; iq_pc = 32'h600;
        tick();
        iq_inst = 32'h00100113; flush = 1'b1; rob_ready = 1'b1;
        #1;
        n_chk++; if (rob_we !== 1'b0 || rs_we !== 4'b0 || iq_ready !== 1'b0) begin n_fail++; $display("FAIL flush_fire: got rob_we=%b rs_we=%b iq_ready=%b want 0/0/0", rob_we, rs_we, iq_ready); end
        tick();
        flush = 1'b0; iq_valid = 1'b0;
        #1;
        n_chk++; if (rob_we !== 1'b0 || iq_ready !== 1'b1 || halted !== 1'b0) begin n_fail++; $display("FAIL flush_empty: got rob_we=%b iq_ready=%b halted=%b want 0/1/0", rob_we, iq_ready, halted); end
        n_chk++; if (cnt_disp !== 32'(exp_disp)) begin n_fail++; $display("FAIL flush_cnt_disp: got %0d want %0d", cnt_disp, exp_disp); end
        tick();
    endtask

    task automatic test_saturate_and_async_reset();
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        iq_valid = 1'b1; iq_inst = 32'h00000013; iq_pc = 32'h700; rob_ready = 1'b0; rs_full = 4'b0000;
        tick();
        iq_valid = 1'b0;
        repeat (20) tick();
        n_chk++; if (s_cnt_stall_rob !== 4'hF) begin n_fail++; $display("FAIL sat_small: got %h want f", s_cnt_stall_rob); end
        n_chk++; if (cnt_stall_rob !== 32'd20 || cnt_stall_rs !== 32'd0) begin n_fail++; $display("FAIL sat_wide: got rob=%0d rs=%0d want 20/0", cnt_stall_rob, cnt_stall_rs); end
        rob_ready = 1'b1; iq_valid = 1'b1;
        #1;
        n_chk++; if (rob_we !== 1'b1 || iq_ready !== 1'b1) begin n_fail++; $display("FAIL pre_reset_fire: got rob_we=%b iq_ready=%b want 1/1", rob_we, iq_ready); end
        #2;
        rst_n = 1'b0;
        #1;
        n_chk++; if (rob_we !== 1'b0 || rob_exc !== 1'b0 || rs_we !== 4'b0 || iq_ready !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL async_reset_strobes: got rob_we=%b exc=%b rs_we=%b iq_ready=%b halted=%b want 0", rob_we, rob_exc, rs_we, iq_ready, halted); end
        n_chk++; if (cnt_stall_rob !== 32'd0 || s_cnt_stall_rob !== 4'h0 || dc_inst !== 32'h0) begin n_fail++; $display("FAIL async_reset_regs: got rob=%0d small=%h inst=%h want 0/0/0", cnt_stall_rob, s_cnt_stall_rob, dc_inst); end
        iq_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        exp_disp = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall_rs();
        test_stall_rob();
        test_illegal();
        test_flush_fire();
        test_saturate_and_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
